multi_seq_ctrl: RTL



---
 rtl/multi_seq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/multi_seq_ctrl.sv
// Full-width unsigned multiply sequencer: splits both operands into halves and
// time-multiplexes the four partial products through one external pipelined multiplier.
module multi_seq_ctrl #(
   parameter int DATA_WIDTH = 2048,
   parameter int MUL_LAT    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   dat1,
   input  logic [DATA_WIDTH-1:0]   dat2,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] product,
   output logic [DATA_WIDTH/2-1:0] mul_dat1,
   output logic [DATA_WIDTH/2-1:0] mul_dat2,
   input  logic [DATA_WIDTH-1:0]   mul_product
);
   localparam int H  = DATA_WIDTH / 2;
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
   typedef enum logic [1:0] {SH_0, SH_H, SH_2H} shift_t;

   typedef struct packed {
      logic   valid;
      shift_t shift;
   } tag_t;

   state_t        state_q, state_d;
   logic [1:0]    k_q, k_d;
   logic [1:0]    rcnt_q, rcnt_d;
   logic [H-1:0]  a_hi_q, a_hi_d, a_lo_q, a_lo_d;
   logic [H-1:0]  b_hi_q, b_hi_d, b_lo_q, b_lo_d;
   logic [H-1:0]  mul_dat1_q, mul_dat1_d, mul_dat2_q, mul_dat2_d;
   logic [PW-1:0] acc_q, acc_d, acc_term;
   logic          out_valid_q, out_valid_d;
   tag_t          tag_q [MUL_LAT];
   tag_t          tag_d [MUL_LAT];
   tag_t          tag_in, tag_out;

   // The tag pipe mirrors the multiplier latency so each result meets its shift code.
   always_comb begin
      tag_d[0] = tag_in;
      for (int i = 1; i < MUL_LAT; i++) tag_d[i] = tag_q[i-1];
   end

   assign tag_out = tag_q[MUL_LAT-1];

   always_comb begin
      case (tag_out.shift)
         SH_0:    acc_term = {{DATA_WIDTH{1'b0}}, mul_product};
         SH_H:    acc_term = {{H{1'b0}}, mul_product, {H{1'b0}}};
         default: acc_term = {mul_product, {DATA_WIDTH{1'b0}}};
      endcase
   end

   always_comb begin
      // NOTE: every signal gets a hold default first so no path can infer a latch.
      state_d     = state_q;
      k_d         = k_q;
      rcnt_d      = rcnt_q;
      a_hi_d      = a_hi_q;
      a_lo_d      = a_lo_q;
      b_hi_d      = b_hi_q;
      b_lo_d      = b_lo_q;
      mul_dat1_d  = mul_dat1_q;
      mul_dat2_d  = mul_dat2_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      tag_in      = '0;

      if (tag_out.valid) begin
         acc_d  = acc_q + acc_term;
         rcnt_d = rcnt_q + 2'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_hi_d     = dat1[DATA_WIDTH-1:H];
               a_lo_d     = dat1[H-1:0];
               b_hi_d     = dat2[DATA_WIDTH-1:H];
               b_lo_d     = dat2[H-1:0];
               mul_dat1_d = dat1[H-1:0];
               mul_dat2_d = dat2[H-1:0];
               acc_d      = '0;
               rcnt_d     = '0;
               k_d        = '0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tag_in.valid = 1'b1;
            case (k_q)
               2'd0:    tag_in.shift = SH_0;
               2'd3:    tag_in.shift = SH_2H;
               default: tag_in.shift = SH_H;
            endcase
            k_d = k_q + 2'd1;
            // Operands registered here are the pair for the next issue slot.
            case (k_q)
               2'd0: begin
                  mul_dat1_d = a_lo_q;
                  mul_dat2_d = b_hi_q;
               end
               2'd1: begin
                  mul_dat1_d = a_hi_q;
                  mul_dat2_d = b_lo_q;
               end
               2'd2: begin
                  mul_dat1_d = a_hi_q;
                  mul_dat2_d = b_hi_q;
               end
               default: state_d = S_DRAIN;
            endcase
         end
         S_DRAIN: begin
            if (tag_out.valid && rcnt_q == 2'd3) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
            end
         end
         default: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are reset too, so mul_dat and product never show X.
         state_q     <= S_IDLE;
         k_q         <= '0;
         rcnt_q      <= '0;
         a_hi_q      <= '0;
         a_lo_q      <= '0;
         b_hi_q      <= '0;
         b_lo_q      <= '0;
         mul_dat1_q  <= '0;
         mul_dat2_q  <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         k_q         <= k_d;
         rcnt_q      <= rcnt_d;
         a_hi_q      <= a_hi_d;
         a_lo_q      <= a_lo_d;
         b_hi_q      <= b_hi_d;
         b_lo_q      <= b_lo_d;
         mul_dat1_q  <= mul_dat1_d;
         mul_dat2_q  <= mul_dat2_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < MUL_LAT; i++) tag_q[i] <= tag_d[i];
      end
   end

   // Gated by rst_n so the block never advertises readiness while held in reset.
   assign in_ready  = rst_n && (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign product   = acc_q;
   assign mul_dat1  = mul_dat1_q;
   assign mul_dat2  = mul_dat2_q;

endmodule
